// File: rtl/mic_frame_writer.sv
// rtl/mic_frame_writer.sv - packs per-mic samples into dual-port RAM, posts a mailbox word, raises irq
// Optional sticky overrun output enabled by defining MIC_FRAME_WRITER_OVERRUN_EN.
module mic_frame_writer #(
   parameter int          MIC_N     = 2,
   parameter int          ADDR_W    = 9,
   parameter int unsigned ADDR_LAST = 2**ADDR_W - 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sample_valid,
   input  logic [16*MIC_N-1:0]   sample_data,
   output logic [ADDR_W-1:0]     ram_address,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [31:0]           ram_writedata,
   output logic [3:0]            ram_byteenable,
   output logic                  ram_clken,
   input  logic [31:0]           ram_readdata,
   output logic                  irq
`ifdef MIC_FRAME_WRITER_OVERRUN_EN
   ,
   output logic                  overrun
`endif
);

   localparam logic [ADDR_W-1:0] LAST_SAMPLE_ADDR = ADDR_W'(MIC_N/2 - 1);
   localparam logic [ADDR_W-1:0] MAILBOX_ADDR     = ADDR_W'(ADDR_LAST);

   typedef enum logic [3:0] {
      INIT,
      WAIT,
      WRITE1,
      WRITE_WAIT,
      WRITE2,
      IRQ_RAISE,
      IRQ_RAISE_WAIT,
      IRQ_WAIT1,
      IRQ_WAIT2,
      IRQ_WAIT3,
      IRQ_RELEASE
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        hist_q, hist_d;
   logic              flag_q, flag_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              edge_det;
   logic [31:0]       sample_word;

   // hist[0] is the metastability stage; only hist[2:1] feed the edge detector
   assign edge_det = hist_q[1] & ~hist_q[2];

   always_comb begin
      sample_word = '0;
      for (int i = 0; i < MIC_N/2; i++) begin
         if (addr_q == ADDR_W'(i)) sample_word = sample_data[32*i +: 32];
      end
   end

   always_comb begin
      hist_d = {hist_q[1:0], sample_valid};
      flag_d = flag_q;
      if (state_q == INIT)  flag_d = 1'b0;
      else if (edge_det)    flag_d = 1'b1;
   end

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      irq            = 1'b0;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      case (state_q)
         INIT: begin
            addr_d  = '0;
            wdata_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (flag_q) state_d = WRITE1;
         end
         WRITE1: begin
            wdata_d = sample_word;
            state_d = WRITE_WAIT;
         end
         WRITE_WAIT: begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            state_d        = (addr_q == LAST_SAMPLE_ADDR) ? IRQ_RAISE : WRITE2;
         end
         WRITE2: begin
            addr_d  = addr_q + 1'b1;
            state_d = WRITE1;
         end
         IRQ_RAISE: begin
            addr_d  = MAILBOX_ADDR;
            wdata_d = 32'd1;
            state_d = IRQ_RAISE_WAIT;
         end
         IRQ_RAISE_WAIT: begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            state_d        = IRQ_WAIT1;
         end
         IRQ_WAIT1: begin
            irq     = 1'b1;
            state_d = IRQ_WAIT2;
         end
         IRQ_WAIT2: begin
            irq            = 1'b1;
            ram_chipselect = 1'b1;
            state_d        = IRQ_WAIT3;
         end
         IRQ_WAIT3: begin
            // mailbox read issued in IRQ_WAIT2 returns here
            irq     = 1'b1;
            state_d = (ram_readdata == 32'd0) ? IRQ_RELEASE : IRQ_WAIT1;
         end
         IRQ_RELEASE: begin
            state_d = INIT;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         hist_q  <= 3'b000;
         flag_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         flag_q  <= flag_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign ram_address    = addr_q;
   assign ram_writedata  = wdata_q;
   assign ram_byteenable = 4'b1111;
   assign ram_clken      = 1'b1;

`ifdef MIC_FRAME_WRITER_OVERRUN_EN
   logic overrun_q, overrun_d;

   always_comb begin
      overrun_d = overrun_q;
      if (edge_det && (state_q != INIT) && (state_q != WAIT)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) overrun_q <= 1'b0;
      else          overrun_q <= overrun_d;
   end

   assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_mic_frame_writer.sv
// tb/tb_mic_frame_writer.sv - directed bench for mic_frame_writer with MIC_N=4 and MIC_N=2 instances
module tb_mic_frame_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sample_valid;
   logic [63:0] sd4;
   logic [31:0] sd2;
   logic [31:0] rd4, rd2;

   logic [8:0]  a4, a2;
   logic        cs4, w4, irq4, cs2, w2, irq2, ck4, ck2;
   logic [31:0] wd4, wd2;
   logic [3:0]  be4, be2;
`ifdef MIC_FRAME_WRITER_OVERRUN_EN
   logic        ov4, ov2;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mic_frame_writer #(.MIC_N(4), .ADDR_W(9)) u4 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sd4),
      .ram_address(a4), .ram_chipselect(cs4), .ram_write(w4), .ram_writedata(wd4),
      .ram_byteenable(be4), .ram_clken(ck4), .ram_readdata(rd4), .irq(irq4)
`ifdef MIC_FRAME_WRITER_OVERRUN_EN
      , .overrun(ov4)
`endif
   );

   mic_frame_writer #(.MIC_N(2), .ADDR_W(9)) u2 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sd2),
      .ram_address(a2), .ram_chipselect(cs2), .ram_write(w2), .ram_writedata(wd2),
      .ram_byteenable(be2), .ram_clken(ck2), .ram_readdata(rd2), .irq(irq2)
`ifdef MIC_FRAME_WRITER_OVERRUN_EN
      , .overrun(ov2)
`endif
   );

   typedef struct packed {
      logic        cs4, w4, irq4;
      logic [8:0]  a4;
      logic [31:0] wd4;
      logic        cs2, w2, irq2;
      logic [8:0]  a2;
      logic [31:0] wd2;
   } vec_t;

   vec_t tbl [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      // one row per cycle after the sample_valid rise; rd held at 1
      tbl[0]  = '{1'b0,1'b0,1'b0,9'd0,  32'h0,        1'b0,1'b0,1'b0,9'd0,  32'h0};
      tbl[1]  = '{1'b0,1'b0,1'b0,9'd0,  32'h0,        1'b0,1'b0,1'b0,9'd0,  32'h0};
      tbl[2]  = '{1'b0,1'b0,1'b0,9'd0,  32'h0,        1'b0,1'b0,1'b0,9'd0,  32'h0};
      tbl[3]  = '{1'b0,1'b0,1'b0,9'd0,  32'h0,        1'b0,1'b0,1'b0,9'd0,  32'h0};
      tbl[4]  = '{1'b1,1'b1,1'b0,9'd0,  32'h00020001, 1'b1,1'b1,1'b0,9'd0,  32'hBEEF1234};
      tbl[5]  = '{1'b0,1'b0,1'b0,9'd0,  32'h00020001, 1'b0,1'b0,1'b0,9'd0,  32'hBEEF1234};
      tbl[6]  = '{1'b0,1'b0,1'b0,9'd1,  32'h00020001, 1'b1,1'b1,1'b0,9'd511,32'h1};
      tbl[7]  = '{1'b1,1'b1,1'b0,9'd1,  32'h00040003, 1'b0,1'b0,1'b1,9'd511,32'h1};
      tbl[8]  = '{1'b0,1'b0,1'b0,9'd1,  32'h00040003, 1'b1,1'b0,1'b1,9'd511,32'h1};
      tbl[9]  = '{1'b1,1'b1,1'b0,9'd511,32'h1,        1'b0,1'b0,1'b1,9'd511,32'h1};
      tbl[10] = '{1'b0,1'b0,1'b1,9'd511,32'h1,        1'b0,1'b0,1'b1,9'd511,32'h1};
      tbl[11] = '{1'b1,1'b0,1'b1,9'd511,32'h1,        1'b1,1'b0,1'b1,9'd511,32'h1};
      tbl[12] = '{1'b0,1'b0,1'b1,9'd511,32'h1,        1'b0,1'b0,1'b1,9'd511,32'h1};
      tbl[13] = '{1'b0,1'b0,1'b1,9'd511,32'h1,        1'b0,1'b0,1'b1,9'd511,32'h1};
      tbl[14] = '{1'b1,1'b0,1'b1,9'd511,32'h1,        1'b1,1'b0,1'b1,9'd511,32'h1};
      tbl[15] = '{1'b0,1'b0,1'b1,9'd511,32'h1,        1'b0,1'b0,1'b1,9'd511,32'h1};

      reset_n      = 1'b0;
      sample_valid = 1'b0;
      sd4          = {16'd4, 16'd3, 16'd2, 16'd1};
      sd2          = {16'hBEEF, 16'h1234};
      rd4          = 32'd1;
      rd2          = 32'd1;
      repeat (3) tick();
      chk("reset_cs", {31'd0, cs4}, 32'd0);
      chk("reset_irq", {31'd0, irq4}, 32'd0);
      chk("reset_addr", {23'd0, a4}, 32'd0);
      chk("reset_wdata", wd4, 32'd0);
      chk("byteenable", {28'd0, be4}, 32'hF);
      chk("clken", {31'd0, ck4}, 32'd1);
`ifdef MIC_FRAME_WRITER_OVERRUN_EN
      chk("reset_overrun", {31'd0, ov4}, 32'd0);
`endif
      reset_n = 1'b1;

      begin
         int bad = 0;
         for (int i = 0; i < 100; i++) begin
            tick();
            if (cs4 || cs2 || irq4 || irq2 || a4 != 9'd0) bad++;
         end
         chk("idle_100", bad, 0);
      end

      sample_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 2) sample_valid = 1'b0;
         chk($sformatf("t%0d_cs4", i+1),  {31'd0, cs4},  {31'd0, tbl[i].cs4});
         chk($sformatf("t%0d_w4", i+1),   {31'd0, w4},   {31'd0, tbl[i].w4});
         chk($sformatf("t%0d_irq4", i+1), {31'd0, irq4}, {31'd0, tbl[i].irq4});
         chk($sformatf("t%0d_a4", i+1),   {23'd0, a4},   {23'd0, tbl[i].a4});
         chk($sformatf("t%0d_wd4", i+1),  wd4,           tbl[i].wd4);
         chk($sformatf("t%0d_cs2", i+1),  {31'd0, cs2},  {31'd0, tbl[i].cs2});
         chk($sformatf("t%0d_w2", i+1),   {31'd0, w2},   {31'd0, tbl[i].w2});
         chk($sformatf("t%0d_irq2", i+1), {31'd0, irq2}, {31'd0, tbl[i].irq2});
         chk($sformatf("t%0d_a2", i+1),   {23'd0, a2},   {23'd0, tbl[i].a2});
         chk($sformatf("t%0d_wd2", i+1),  wd2,           tbl[i].wd2);
      end

      // ten further polls with mailbox still set; second edge arrives mid-wait
      for (int p = 0; p < 10; p++) begin
         for (int k = 0; k < 3; k++) begin
            if (p == 2 && k == 0) sample_valid = 1'b1;
            tick();
            chk($sformatf("poll%0d_%0d_irq4", p, k), {31'd0, irq4}, 32'd1);
            chk($sformatf("poll%0d_%0d_irq2", p, k), {31'd0, irq2}, 32'd1);
            chk($sformatf("poll%0d_%0d_cs4", p, k), {31'd0, cs4}, (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("poll%0d_%0d_cs2", p, k), {31'd0, cs2}, (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("poll%0d_%0d_w4", p, k), {31'd0, w4}, 32'd0);
            if (p == 9 && k == 1) begin
               rd4 = 32'd0;
               rd2 = 32'd0;
            end
         end
      end
      tick();
      chk("release_irq4", {31'd0, irq4}, 32'd0);
      chk("release_irq2", {31'd0, irq2}, 32'd0);
`ifdef MIC_FRAME_WRITER_OVERRUN_EN
      chk("overrun4", {31'd0, ov4}, 32'd1);
      chk("overrun2", {31'd0, ov2}, 32'd1);
`endif

      begin
         int bad = 0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (cs4 || cs2 || irq4 || irq2) bad++;
            if (i >= 1 && (a4 != 9'd0 || a2 != 9'd0)) bad++;
         end
         chk("no_repeat_frame", bad, 0);
      end

      // reset in the middle of the first write strobe
      sample_valid = 1'b0;
      repeat (4) tick();
      sample_valid = 1'b1;
      repeat (5) tick();
      chk("pre_reset_cs4", {31'd0, cs4}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_cs4", {31'd0, cs4}, 32'd0);
      chk("async_w4", {31'd0, w4}, 32'd0);
      chk("async_irq4", {31'd0, irq4}, 32'd0);
      chk("async_a4", {23'd0, a4}, 32'd0);
      chk("async_wd4", wd4, 32'd0);
      chk("async_cs2", {31'd0, cs2}, 32'd0);
`ifdef MIC_FRAME_WRITER_OVERRUN_EN
      chk("async_overrun", {31'd0, ov4}, 32'd0);
`endif
      sample_valid = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      sd4          = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
      sample_valid = 1'b1;
      repeat (5) tick();
      chk("post_w0_cs", {31'd0, cs4}, 32'd1);
      chk("post_w0_addr", {23'd0, a4}, 32'd0);
      chk("post_w0_data", wd4, 32'h000B000A);
      repeat (3) tick();
      chk("post_w1_cs", {31'd0, cs4}, 32'd1);
      chk("post_w1_addr", {23'd0, a4}, 32'd1);
      chk("post_w1_data", wd4, 32'h000D000C);
      repeat (2) tick();
      chk("post_mbox_cs", {31'd0, cs4 & w4}, 32'd1);
      chk("post_mbox_addr", {23'd0, a4}, 32'd511);
      chk("post_mbox_data", wd4, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mic_frame_writer.md
Name: mic_frame_writer

Overview:
- Collects one 16-bit decimated sample per microphone from the parallel PDM filter chains.
- Runs in the system clock domain.
- On each new sample set, writes all samples, packed two per 32-bit word, into a dual-port RAM slave.
- Writes a "frame ready" word to the last RAM address and raises an IRQ to the Nios core.
- Holds the IRQ until the host clears that word to zero.

Parameters:
- MIC_N, 2: number of microphones; must be even and ≥2.
- ADDR_W, 9: RAM word-address width.
- ADDR_LAST, 2**ADDR_W-1 (511): word address of the frame-ready mailbox.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  filter output-valid of mic 0, from the slower filter clock domain; unsynchronised.
- sample_data  in  16*MIC_N  mic k sample at bits [16k+15:16k].
- ram_address  out  ADDR_W  word address.
- ram_chipselect  out  1  RAM access strobe.
- ram_write  out  1  1 = write, 0 = read, qualified by ram_chipselect.
- ram_writedata  out  32  write data.
- ram_byteenable  out  4  constant 4'b1111.
- ram_clken  out  1  constant 1.
- ram_readdata  in  32  RAM read data; valid the cycle after the read strobe (1-cycle latency).
- irq  out  1  interrupt request to the host.

Behaviour:

Reset (reset_n low, asynchronous):
- state = INIT; ram_address = 0; ram_writedata = 0; sync history = 3'b000; flag = 0.
- Combinational outputs follow from state INIT: irq = 0, ram_chipselect = 0, ram_write = 0.

Synchroniser and flag:
- Each clk: hist <= {hist[1:0], sample_valid}.
- Rising edge is detected when hist[1] & ~hist[2].
- The flag clears whenever state == INIT (clear has priority over set).
- Otherwise an edge sets the flag; otherwise it holds.
- An edge during a frame sets the flag but is discarded at the next INIT. Only edges seen in WAIT start frames.

FSM (registered; default next = current):
- INIT → WAIT. Actions: ram_address <= 0; ram_writedata <= 0.
- WAIT → WRITE1 when flag = 1.
- WRITE1 → WRITE_WAIT. Action: ram_writedata <= {sample(2*addr+1), sample(2*addr)}.
- WRITE_WAIT: ram_chipselect = 1, ram_write = 1. Next is IRQ_RAISE if ram_address == MIC_N/2-1, else WRITE2.
- WRITE2 → WRITE1. Action: ram_address <= ram_address + 1.
- IRQ_RAISE → IRQ_RAISE_WAIT. Actions: ram_address <= ADDR_LAST; ram_writedata <= 1.
- IRQ_RAISE_WAIT → IRQ_WAIT1. Outputs: ram_chipselect = 1, ram_write = 1 (mailbox write).
- IRQ_WAIT1 → IRQ_WAIT2. Output: irq = 1.
- IRQ_WAIT2 → IRQ_WAIT3. Outputs: irq = 1, ram_chipselect = 1, ram_write = 0 (mailbox read).
- IRQ_WAIT3: irq = 1. Next is IRQ_RELEASE if ram_readdata == 0, else IRQ_WAIT1 (poll every 3 cycles).
- IRQ_RELEASE → INIT. Output: irq = 0.

Output and timing rules:
- irq, ram_chipselect and ram_write are decoded combinationally from state.
- ram_address and ram_writedata are registered.
- Latency from the sample_valid rising edge to the first RAM write strobe: 2 sync cycles + 1 flag + WAIT→WRITE1→WRITE_WAIT, i.e. the strobe appears at cycle 5.
- A frame of MIC_N/2 words takes 3*(MIC_N/2)-1 cycles from WRITE1 to the last strobe.
- No write occurs outside WRITE_WAIT and IRQ_RAISE_WAIT.
- ram_address never exceeds MIC_N/2-1 during the sample phase.
- Reset mid-frame: immediate return to reset values; irq drops asynchronously.

Optional Feature:
- Macro: MIC_FRAME_WRITER_OVERRUN_EN.
- Defined:
  - Adds output port overrun (1 bit, sticky, reset 0).
  - overrun sets when a synchronised rising edge occurs in any state other than INIT/WAIT.
  - It clears only on reset_n.
- Undefined: no port is added and there is no extra logic; all other behaviour is identical.

Test Plan:
- Reset release, sample_valid held 0 for 100 cycles → no chipselect, irq = 0, ram_address = 0.
- MIC_N=2, sample_data = {16'hBEEF, 16'h1234}, pulse sample_valid → one write of 32'hBEEF1234 at addr 0 on cycle 5 after the edge. Then a write of 32'h1 to addr 511 and irq = 1.
- MIC_N=4, data {4,3,2,1}:
  - writes 32'h00020001 at addr 0, then 32'h00040003 at addr 1, three cycles apart;
  - then the mailbox write;
  - no addr 2.
- Readdata held at 1 for 10 polls → irq stays 1, read strobe every 3rd cycle. Set readdata to 0 → irq falls 2 cycles later, FSM returns to WAIT.
- Second sample_valid edge during the IRQ wait → frame not repeated after release. With MIC_FRAME_WRITER_OVERRUN_EN, overrun = 1.
- Assert reset_n low during WRITE_WAIT → irq/chipselect/write drop immediately, address = 0. The next edge after release produces a normal frame.
